multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control unit for the 64-bit RISC-V core. It sequences the shared datapath: PC register, instruction register, register file, `ula64`, and the instruction and data memories. It steps each instruction through fetch, decode, execute, memory and writeback states. It replaces the fetch-only state machine and drives every load strobe, mux select and ALU selector from a single FSM.

## Interface
Parameters:
- none (all codes are fixed in `ctrl_pkg`)

Ports:
- `CLK`  in  1  — single clock; all state changes on the rising edge.
- `RST`  in  1  — asynchronous, active-low reset.
- `OPCODE`  in  7  — IR[6:0].
- `FUNCT3`  in  3  — IR[14:12].
- `FUNCT7_5`  in  1  — IR[30].
- `ZERO`  in  1  — ula64 result-equals-zero flag.
- `RESET_DP`  out  1  — synchronous clear to PC and datapath registers.
- `PC_WRITE`  out  1  — PC load enable.
- `PC_SRC`  out  1  — PC input select: 0 = ALU result, 1 = ALUOUT.
- `LOAD_IR`  out  1  — load IR and OLD_PC.
- `LOAD_AB`  out  1  — load A/B from the register file.
- `LOAD_ALUOUT`  out  1  — load ALUOUT.
- `LOAD_MDR`  out  1  — load MDR.
- `DMEM_WR`  out  1  — data memory write.
- `REG_WRITE`  out  1  — register file write.
- `WB_SEL`  out  2  — writeback source: 0 = ALUOUT, 1 = MDR, 2 = PC, 3 = IMM.
- `ALU_SRC_A`  out  2  — ALU A input: 0 = PC, 1 = A, 2 = OLD_PC.
- `ALU_SRC_B`  out  2  — ALU B input: 0 = B, 1 = constant 4, 2 = IMM.
- `ALU_OP`  out  3  — ula64 selector: 001 add, 010 sub, 011 and.
- `IMM_SEL`  out  3  — immediate format: 0 = I, 1 = S, 2 = B, 3 = J, 4 = U.
- `INSTR_DONE`  out  1  — one-cycle pulse in the last state of each instruction.
- `ILLEGAL`  out  1  — high while halted on an unsupported instruction.
- `STATE`  out  4  — current state encoding, for debug.

## Operation
Supported instructions (anything else is illegal):
- R-type (0110011): add (funct3 000, FUNCT7_5 = 0), sub (funct3 000, FUNCT7_5 = 1), and (funct3 111).
- addi: 0010011, funct3 000.
- ld: 0000011, funct3 011.
- sd: 0100011, funct3 111.
- beq / bne: 1100011, funct3 000 / 001.
- jal: 1101111.
- lui: 0110111.

State sequence and strobes:
- RESET_ST: `RESET_DP` = 1 → FETCH.
- FETCH: PC drives the instruction memory address; no strobes → FETCH_WAIT.
- FETCH_WAIT: `LOAD_IR`; `PC_WRITE` with `ALU_SRC_A` = 0, `ALU_SRC_B` = 1, add, `PC_SRC` = 0 (PC ← PC + 4) → DECODE.
- DECODE: `LOAD_AB`; `LOAD_ALUOUT` with `ALU_SRC_A` = 2, `ALU_SRC_B` = 2, add (ALUOUT ← OLD_PC + imm).
  - Legality is checked here.
  - Next state by class: EXEC_R, EXEC_I, MEM_ADDR, BRANCH, JAL, LUI, or HALT.
- EXEC_R: A op B into ALUOUT → WB_ALU.
- EXEC_I: A + IMM into ALUOUT → WB_ALU.
- WB_ALU: `REG_WRITE`, `WB_SEL` = 0, done.
- MEM_ADDR: ALUOUT ← A + IMM.
  - Load → MEM_READ.
  - Store → MEM_WRITE.
- MEM_READ: data memory address = ALUOUT → MEM_READ_WAIT.
- MEM_READ_WAIT: `LOAD_MDR` → WB_LOAD.
- WB_LOAD: `REG_WRITE`, `WB_SEL` = 1, done.
- MEM_WRITE: `DMEM_WR` = 1, done.
- BRANCH: A − B.
  - `PC_WRITE` = (beq & `ZERO`) | (bne & !`ZERO`), with `PC_SRC` = 1.
  - Done.
- JAL: `PC_WRITE` with `PC_SRC` = 1; `REG_WRITE` with `WB_SEL` = 2 (writes PC + 4, the already-incremented PC); done.
- LUI: `REG_WRITE`, `WB_SEL` = 3, done.
- HALT: `ILLEGAL` = 1; all strobes 0; stays here until `RST`.

General rules:
- Every "done" state pulses `INSTR_DONE` and returns to FETCH.
- `IMM_SEL` is decoded from `OPCODE` in every state.

## Timing
- Reset value of every output: 0, with two exceptions.
  - `RESET_DP` is 1 while `RST` = 0 and for one cycle in RESET_ST after release.
  - `STATE` is RESET_ST.
- Reset asserted mid-instruction aborts it immediately. No write strobe may be high while `RST` = 0.
- Outputs are combinational from the state register plus the IR fields. `PC_WRITE` in BRANCH also depends on `ZERO`.
- IR fields are valid from DECODE onward. They are not used in FETCH or FETCH_WAIT.
- Instruction latency in cycles, FETCH to done inclusive:
  - R / addi: 5
  - ld: 7
  - sd: 5
  - beq / bne: 4
  - jal / lui: 4
- Memories have one-cycle synchronous read latency, hence the WAIT states.
- At most one of `REG_WRITE`, `DMEM_WR` per cycle, except JAL, which asserts `REG_WRITE` and `PC_WRITE` together.

## Structure
- `ctrl_pkg` contains:
  - the state enum (4-bit)
  - opcode and funct3 constants
  - `ALU_OP` codes
  - `WB_SEL`, `ALU_SRC_A`, `ALU_SRC_B` and `IMM_SEL` codes
  - the instruction-class enum
- One sub-module, `ctrl_decode`: combinational map of `OPCODE`, `FUNCT3` and `FUNCT7_5` to instruction class, `IMM_SEL`, R-type `ALU_OP` and legal flag.
- The FSM and output decode live in `multicycle_ctrl`.

## Test plan
- Release `RST` → `RESET_DP` high for 1 cycle, then FETCH; `PC_WRITE` exactly in cycle 3.
- add (0110011, f3 000, f7_5 0) → 5 cycles; EXEC_R `ALU_OP` = 001; WB_ALU `REG_WRITE` = 1, `WB_SEL` = 0; `INSTR_DONE` pulse.
- sub then and → `ALU_OP` 010 then 011 in EXEC_R.
- ld (f3 011) → 7 cycles; `LOAD_MDR` in cycle 6; `WB_SEL` = 1 in cycle 7. sd (f3 111) → `DMEM_WR` = 1 only in cycle 5.
- beq with `ZERO` = 1 and with `ZERO` = 0, then bne with `ZERO` = 0 → `PC_WRITE`/`PC_SRC` = 1/1, 0/x, 1/1.
  - jal → `PC_WRITE` and `REG_WRITE` together with `WB_SEL` = 2.
  - lui → `WB_SEL` = 3.
- Opcode 1111111 → HALT with `ILLEGAL` = 1 and zero strobes for 20 cycles. Then assert `RST` mid-HALT and separately mid-ld (MEM_READ) → all strobes 0 immediately, restart at RESET_ST.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------
// ctrl_pkg : state, opcode and datapath-select codes for the core
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package ctrl_pkg;

  typedef enum logic [3:0] {
    RESET_ST      = 4'd0,
    FETCH         = 4'd1,
    FETCH_WAIT    = 4'd2,
    DECODE        = 4'd3,
    EXEC_R        = 4'd4,
    EXEC_I        = 4'd5,
    WB_ALU        = 4'd6,
    MEM_ADDR      = 4'd7,
    MEM_READ      = 4'd8,
    MEM_READ_WAIT = 4'd9,
    WB_LOAD       = 4'd10,
    MEM_WRITE     = 4'd11,
    BRANCH        = 4'd12,
    JAL           = 4'd13,
    LUI           = 4'd14,
    HALT          = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_LUI, CLS_ILLEGAL
  } instr_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_SD  = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;
  localparam logic [1:0] WB_IMM    = 2'd3;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_A     = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------
// multicycle_ctrl_if : IR fields/flags in, datapath strobes out
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface multicycle_ctrl_if;
  logic [6:0] OPCODE;
  logic [2:0] FUNCT3;
  logic       FUNCT7_5;
  logic       ZERO;
  logic       RESET_DP;
  logic       PC_WRITE;
  logic       PC_SRC;
  logic       LOAD_IR;
  logic       LOAD_AB;
  logic       LOAD_ALUOUT;
  logic       LOAD_MDR;
  logic       DMEM_WR;
  logic       REG_WRITE;
  logic [1:0] WB_SEL;
  logic [1:0] ALU_SRC_A;
  logic [1:0] ALU_SRC_B;
  logic [2:0] ALU_OP;
  logic [2:0] IMM_SEL;
  logic       INSTR_DONE;
  logic       ILLEGAL;
  logic [3:0] STATE;

  modport master (
    input  OPCODE, FUNCT3, FUNCT7_5, ZERO,
    output RESET_DP, PC_WRITE, PC_SRC, LOAD_IR, LOAD_AB, LOAD_ALUOUT, LOAD_MDR,
           DMEM_WR, REG_WRITE, WB_SEL, ALU_SRC_A, ALU_SRC_B, ALU_OP, IMM_SEL,
           INSTR_DONE, ILLEGAL, STATE
  );

  modport slave (
    output OPCODE, FUNCT3, FUNCT7_5, ZERO,
    input  RESET_DP, PC_WRITE, PC_SRC, LOAD_IR, LOAD_AB, LOAD_ALUOUT, LOAD_MDR,
           DMEM_WR, REG_WRITE, WB_SEL, ALU_SRC_A, ALU_SRC_B, ALU_OP, IMM_SEL,
           INSTR_DONE, ILLEGAL, STATE
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
// ---------------------------------------------------------------
// ctrl_decode : IR fields to instruction class, imm format, R-op
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  output instr_class_t iclass,
  output logic [2:0]   imm_sel,
  output logic [2:0]   r_alu_op,
  output logic         legal
);

  always_comb begin
    iclass   = CLS_ILLEGAL;
    imm_sel  = IMM_I;
    r_alu_op = ALU_ADD;
    unique case (opcode)
      OP_R: begin
        if (funct3 == F3_ADD) begin
          iclass   = CLS_R;
          r_alu_op = funct7_5 ? ALU_SUB : ALU_ADD;
        end else if (funct3 == F3_AND) begin
          iclass   = CLS_R;
          r_alu_op = ALU_AND;
        end
      end
      OP_IMM:    if (funct3 == F3_ADD) iclass = CLS_I;
      OP_LOAD:   if (funct3 == F3_LD)  iclass = CLS_LOAD;
      OP_STORE: begin
        imm_sel = IMM_S;
        if (funct3 == F3_SD) iclass = CLS_STORE;
      end
      OP_BRANCH: begin
        imm_sel = IMM_B;
        if (funct3 == F3_BEQ || funct3 == F3_BNE) iclass = CLS_BRANCH;
      end
      OP_JAL: begin
        imm_sel = IMM_J;
        iclass  = CLS_JAL;
      end
      OP_LUI: begin
        imm_sel = IMM_U;
        iclass  = CLS_LUI;
      end
      default: ;
    endcase
  end

  assign legal = (iclass != CLS_ILLEGAL);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------
// multicycle_ctrl : single FSM driving every datapath strobe/select
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  multicycle_ctrl_if.master bus
);

  state_t       state_q, state_d;
  instr_class_t iclass;
  logic [2:0]   dec_imm_sel;
  logic [2:0]   r_alu_op;
  logic         legal;
  logic         br_taken;

  ctrl_decode u_decode (
    .opcode   (bus.OPCODE),
    .funct3   (bus.FUNCT3),
    .funct7_5 (bus.FUNCT7_5),
    .iclass   (iclass),
    .imm_sel  (dec_imm_sel),
    .r_alu_op (r_alu_op),
    .legal    (legal)
  );

  // Async reset forces RESET_ST, so every strobe drops the moment RST falls.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= RESET_ST;
    else      state_q <= state_d;
  end

  assign br_taken = ((bus.FUNCT3 == F3_BEQ) &&  bus.ZERO) ||
                    ((bus.FUNCT3 == F3_BNE) && !bus.ZERO);

  always_comb begin
    state_d         = state_q;
    bus.RESET_DP    = 1'b0;
    bus.PC_WRITE    = 1'b0;
    bus.PC_SRC      = 1'b0;
    bus.LOAD_IR     = 1'b0;
    bus.LOAD_AB     = 1'b0;
    bus.LOAD_ALUOUT = 1'b0;
    bus.LOAD_MDR    = 1'b0;
    bus.DMEM_WR     = 1'b0;
    bus.REG_WRITE   = 1'b0;
    bus.WB_SEL      = WB_ALUOUT;
    bus.ALU_SRC_A   = SRCA_PC;
    bus.ALU_SRC_B   = SRCB_B;
    bus.ALU_OP      = ALU_NOP;
    bus.INSTR_DONE  = 1'b0;
    bus.ILLEGAL     = 1'b0;
    bus.STATE       = state_q;
    bus.IMM_SEL     = (state_q == RESET_ST) ? IMM_I : dec_imm_sel;

    unique case (state_q)
      RESET_ST: begin
        bus.RESET_DP = 1'b1;
        state_d      = FETCH;
      end
      FETCH: state_d = FETCH_WAIT;
      FETCH_WAIT: begin
        bus.LOAD_IR   = 1'b1;
        bus.PC_WRITE  = 1'b1;
        bus.ALU_SRC_B = SRCB_FOUR;
        bus.ALU_OP    = ALU_ADD;
        state_d       = DECODE;
      end
      DECODE: begin
        // Branch/jump target is precomputed here so BRANCH and JAL can use ALUOUT.
        bus.LOAD_AB     = 1'b1;
        bus.LOAD_ALUOUT = 1'b1;
        bus.ALU_SRC_A   = SRCA_OLDPC;
        bus.ALU_SRC_B   = SRCB_IMM;
        bus.ALU_OP      = ALU_ADD;
        unique case (iclass)
          CLS_R:                state_d = EXEC_R;
          CLS_I:                state_d = EXEC_I;
          CLS_LOAD, CLS_STORE:  state_d = MEM_ADDR;
          CLS_BRANCH:           state_d = BRANCH;
          CLS_JAL:              state_d = JAL;
          CLS_LUI:              state_d = LUI;
          default:              state_d = HALT;
        endcase
      end
      EXEC_R: begin
        bus.LOAD_ALUOUT = 1'b1;
        bus.ALU_SRC_A   = SRCA_A;
        bus.ALU_OP      = r_alu_op;
        state_d         = WB_ALU;
      end
      EXEC_I, MEM_ADDR: begin
        bus.LOAD_ALUOUT = 1'b1;
        bus.ALU_SRC_A   = SRCA_A;
        bus.ALU_SRC_B   = SRCB_IMM;
        bus.ALU_OP      = ALU_ADD;
        if (state_q == EXEC_I)         state_d = WB_ALU;
        else if (iclass == CLS_LOAD)   state_d = MEM_READ;
        else                           state_d = MEM_WRITE;
      end
      WB_ALU: begin
        bus.REG_WRITE  = 1'b1;
        bus.INSTR_DONE = 1'b1;
        state_d        = FETCH;
      end
      MEM_READ: state_d = MEM_READ_WAIT;
      MEM_READ_WAIT: begin
        bus.LOAD_MDR = 1'b1;
        state_d      = WB_LOAD;
      end
      WB_LOAD: begin
        bus.REG_WRITE  = 1'b1;
        bus.WB_SEL     = WB_MDR;
        bus.INSTR_DONE = 1'b1;
        state_d        = FETCH;
      end
      MEM_WRITE: begin
        bus.DMEM_WR    = 1'b1;
        bus.INSTR_DONE = 1'b1;
        state_d        = FETCH;
      end
      BRANCH: begin
        bus.ALU_SRC_A  = SRCA_A;
        bus.ALU_OP     = ALU_SUB;
        bus.PC_SRC     = 1'b1;
        bus.PC_WRITE   = br_taken;
        bus.INSTR_DONE = 1'b1;
        state_d        = FETCH;
      end
      JAL: begin
        bus.PC_WRITE   = 1'b1;
        bus.PC_SRC     = 1'b1;
        bus.REG_WRITE  = 1'b1;
        bus.WB_SEL     = WB_PC;
        bus.INSTR_DONE = 1'b1;
        state_d        = FETCH;
      end
      LUI: begin
        bus.REG_WRITE  = 1'b1;
        bus.WB_SEL     = WB_IMM;
        bus.INSTR_DONE = 1'b1;
        state_d        = FETCH;
      end
      HALT: bus.ILLEGAL = 1'b1;
      default: state_d = RESET_ST;
    endcase
  end

  logic unused_legal;
  assign unused_legal = legal;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------
// tb_multicycle_ctrl : scoreboard bench, per-cycle expected strobes
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl;

  typedef struct packed {
    logic       reset_dp, pc_write, pc_src, load_ir, load_ab, load_aluout, load_mdr, dmem_wr, reg_write;
    logic [1:0] wb_sel, src_a, src_b;
    logic [2:0] alu_op, imm_sel;
    logic       done, illegal;
    logic [3:0] state;
  } out_t;

  typedef struct {
    out_t  v;
    string tag;
  } exp_t;

  logic CLK;
  logic RST;
  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  exp_t q[$];
  event ev_chk;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail_x = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic out_t exp_out(input logic [3:0] st, input logic [2:0] imm,
                                   input logic [2:0] rop, input logic taken);
    out_t o;
    o         = '0;
    o.state   = st;
    o.imm_sel = (st == 4'd0) ? 3'd0 : imm;
    case (st)
      4'd0:  o.reset_dp = 1'b1;
      4'd2:  begin o.load_ir = 1; o.pc_write = 1; o.src_b = 2'd1; o.alu_op = 3'b001; end
      4'd3:  begin o.load_ab = 1; o.load_aluout = 1; o.src_a = 2'd2; o.src_b = 2'd2; o.alu_op = 3'b001; end
      4'd4:  begin o.load_aluout = 1; o.src_a = 2'd1; o.src_b = 2'd0; o.alu_op = rop; end
      4'd5:  begin o.load_aluout = 1; o.src_a = 2'd1; o.src_b = 2'd2; o.alu_op = 3'b001; end
      4'd6:  begin o.reg_write = 1; o.wb_sel = 2'd0; o.done = 1; end
      4'd7:  begin o.load_aluout = 1; o.src_a = 2'd1; o.src_b = 2'd2; o.alu_op = 3'b001; end
      4'd9:  o.load_mdr = 1'b1;
      4'd10: begin o.reg_write = 1; o.wb_sel = 2'd1; o.done = 1; end
      4'd11: begin o.dmem_wr = 1; o.done = 1; end
      4'd12: begin o.src_a = 2'd1; o.src_b = 2'd0; o.alu_op = 3'b010; o.pc_src = 1; o.pc_write = taken; o.done = 1; end
      4'd13: begin o.pc_write = 1; o.pc_src = 1; o.reg_write = 1; o.wb_sel = 2'd2; o.done = 1; end
      4'd14: begin o.reg_write = 1; o.wb_sel = 2'd3; o.done = 1; end
      4'd15: o.illegal = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic step(input string tag, input out_t e);
    exp_t x;
    @(posedge CLK);
    #1;
    x.v   = e;
    x.tag = tag;
    q.push_back(x);
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f75, input logic zero, input logic [2:0] imm,
                           input logic [2:0] rop, input logic taken,
                           input logic [31:0] seq, input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      if (i == 0) begin
        bus.OPCODE   = op;
        bus.FUNCT3   = f3;
        bus.FUNCT7_5 = f75;
        bus.ZERO     = zero;
      end
      x.v   = exp_out(seq[i*4 +: 4], imm, rop, taken);
      x.tag = tag;
      q.push_back(x);
    end
  endtask

  task automatic abort(input string tag);
    exp_t x;
    @(negedge CLK);
    #1;
    RST = 1'b0;
    #1;
    x.v   = exp_out(4'd0, 3'd0, 3'd0, 1'b0);
    x.tag = tag;
    q.push_back(x);
    -> ev_chk;
    step({tag, "_hold"}, exp_out(4'd0, 3'd0, 3'd0, 1'b0));
    @(posedge CLK);
    #1;
    RST   = 1'b1;
    x.tag = {tag, "_release"};
    q.push_back(x);
  endtask

  initial begin
    exp_t e;
    out_t got;
    forever begin
      @(negedge CLK or ev_chk);
      if ((bus.REG_WRITE & bus.DMEM_WR) !== 1'b0) begin
        n_fail_x++;
        $display("FAIL excl t=%0t: got REG_WRITE=%b DMEM_WR=%b required not both high",
                 $time, bus.REG_WRITE, bus.DMEM_WR);
      end
      if (bus.RESET_DP !== (bus.STATE === 4'd0)) begin
        n_fail_x++;
        $display("FAIL reset_dp t=%0t: got RESET_DP=%b STATE=%0d required RESET_DP only in RESET_ST",
                 $time, bus.RESET_DP, bus.STATE);
      end
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {bus.RESET_DP, bus.PC_WRITE, bus.PC_SRC, bus.LOAD_IR, bus.LOAD_AB,
               bus.LOAD_ALUOUT, bus.LOAD_MDR, bus.DMEM_WR, bus.REG_WRITE, bus.WB_SEL,
               bus.ALU_SRC_A, bus.ALU_SRC_B, bus.ALU_OP, bus.IMM_SEL, bus.INSTR_DONE,
               bus.ILLEGAL, bus.STATE};
        n_checks++;
        if (got === e.v) n_pass++;
        else $display("FAIL %s t=%0t: got %h (state %0d) required %h (state %0d)",
                      e.tag, $time, got, got.state, e.v, e.v.state);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.OPCODE   = 7'h00;
    bus.FUNCT3   = 3'd0;
    bus.FUNCT7_5 = 1'b0;
    bus.ZERO     = 1'b0;
    RST          = 1'b1;
    #2 RST = 1'b0;

    for (int i = 0; i < 3; i++) step("reset", exp_out(4'd0, 3'd0, 3'd0, 1'b0));
    @(posedge CLK);
    #1;
    RST = 1'b1;
    q.push_back('{v: exp_out(4'd0, 3'd0, 3'd0, 1'b0), tag: "reset_release"});

    run_instr("add",   7'h33, 3'd0, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 32'h00064321, 5);
    run_instr("sub",   7'h33, 3'd0, 1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 32'h00064321, 5);
    run_instr("and",   7'h33, 3'd7, 1'b0, 1'b0, 3'd0, 3'd3, 1'b0, 32'h00064321, 5);
    run_instr("addi",  7'h13, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'h00065321, 5);
    run_instr("ld",    7'h03, 3'd3, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'h0A987321, 7);
    run_instr("sd",    7'h23, 3'd7, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 32'h000B7321, 5);
    run_instr("beq_z1",7'h63, 3'd0, 1'b0, 1'b1, 3'd2, 3'd0, 1'b1, 32'h0000C321, 4);
    run_instr("beq_z0",7'h63, 3'd0, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0, 32'h0000C321, 4);
    run_instr("bne_z0",7'h63, 3'd1, 1'b0, 1'b0, 3'd2, 3'd0, 1'b1, 32'h0000C321, 4);
    run_instr("bne_z1",7'h63, 3'd1, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 32'h0000C321, 4);
    run_instr("jal",   7'h6F, 3'd0, 1'b0, 1'b0, 3'd3, 3'd0, 1'b0, 32'h0000D321, 4);
    run_instr("lui",   7'h37, 3'd0, 1'b0, 1'b0, 3'd4, 3'd0, 1'b0, 32'h0000E321, 4);

    run_instr("illegal", 7'h7F, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'h0000F321, 4);
    for (int i = 0; i < 19; i++) step("halt", exp_out(4'd15, 3'd0, 3'd0, 1'b0));
    abort("rst_in_halt");

    run_instr("ld_abort", 7'h03, 3'd3, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'h00087321, 5);
    abort("rst_in_memread");

    run_instr("add_after", 7'h33, 3'd0, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 32'h00064321, 5);

    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_checks < 12)
        $display("FAIL count: got %0d checks required at least 12", n_checks);
    if (n_pass !== n_checks)
        $display("FAIL summary: got %0d passes required %0d", n_pass, n_checks);
    if (n_fail_x != 0)
        $display("FAIL invariants: got %0d violations required 0", n_fail_x);
    if (n_checks >= 12 && n_pass == n_checks && n_fail_x == 0)
        $display("PASS");
    $finish;
  end

endmodule

`default_nettype wire
